// File: rtl/csum_pkg.sv
// Shared types, defaults and helpers for the checksum-beat inserter.
package csum_pkg;

  localparam int DATA_W_DEFAULT = 512;
  localparam int KEEP_W_DEFAULT = DATA_W_DEFAULT / 8;
  localparam int ID_W_DEFAULT   = 6;
  localparam int GROUP_DEFAULT  = 4;

  typedef struct packed {
    logic [DATA_W_DEFAULT-1:0] data;
    logic [KEEP_W_DEFAULT-1:0] keep;
    logic [ID_W_DEFAULT-1:0]   id;
    logic                      last;
  } beat_t;

  typedef enum logic {S_DATA, S_CSUM} state_t;

  // Zero every byte whose enable is clear.
  function automatic logic [DATA_W_DEFAULT-1:0] keep_mask(
    input logic [DATA_W_DEFAULT-1:0] data,
    input logic [KEEP_W_DEFAULT-1:0] keep
  );
    logic [DATA_W_DEFAULT-1:0] m;
    m = '0;
    for (int b = 0; b < KEEP_W_DEFAULT; b++) begin
      if (keep[b]) m[b*8 +: 8] = data[b*8 +: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/csum_out_reg.sv
// Single-entry output register; free means a new beat may be loaded this cycle.
module csum_out_reg #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] beat_i,
  input  logic         out_ready_i,
  output logic [W-1:0] beat_o,
  output logic         valid_o,
  output logic         free_o
);

  logic [W-1:0] beat_q;
  logic         valid_q;

  assign free_o  = !valid_q || out_ready_i;
  assign beat_o  = beat_q;
  assign valid_o = valid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      beat_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      beat_q  <= beat_i;
      valid_q <= 1'b1;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/caesar_csum_inserter.sv
// Inserts a byte-masked XOR checksum beat after every GROUP data beats and
// after the final beat of each packet.
module caesar_csum_inserter
  import csum_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = ID_W_DEFAULT,
  parameter int GROUP  = GROUP_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] inp_data,
  input  logic              inp_valid,
  output logic              inp_ready,
  input  logic [KEEP_W-1:0] inp_keep,
  input  logic [ID_W-1:0]   inp_id,
  input  logic              inp_last,
  output logic [DATA_W-1:0] out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [KEEP_W-1:0] out_keep,
  output logic [ID_W-1:0]   out_id,
  output logic              out_last
);

  localparam int CNT_W  = $clog2(GROUP);
  localparam int BEAT_W = DATA_W + KEEP_W + ID_W + 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   csum_q, csum_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                pend_last_q, pend_last_d;

  logic [DATA_W-1:0]   masked;
  logic                free;
  logic                load;
  logic [BEAT_W-1:0]   load_beat;
  logic [BEAT_W-1:0]   out_beat;

  for (genvar gi = 0; gi < KEEP_W; gi++) begin : g_mask
    assign masked[gi*8 +: 8] = inp_keep[gi] ? inp_data[gi*8 +: 8] : 8'h00;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_DATA;
      cnt_q       <= '0;
      acc_q       <= '0;
      csum_q      <= '0;
      id_q        <= '0;
      pend_last_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      csum_q      <= csum_d;
      id_q        <= id_d;
      pend_last_q <= pend_last_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    csum_d      = csum_q;
    id_d        = id_q;
    pend_last_d = pend_last_q;
    inp_ready   = 1'b0;
    load        = 1'b0;
    load_beat   = {inp_data, inp_keep, inp_id, 1'b0};
    case (state_q)
      S_DATA: begin
        inp_ready = free;
        if (inp_valid && free) begin
          load   = 1'b1;
          csum_d = acc_q ^ masked;
          id_d   = inp_id;
          if (cnt_q == CNT_W'(GROUP - 1) || inp_last) begin
            state_d     = S_CSUM;
            pend_last_d = inp_last;
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            acc_d = acc_q ^ masked;
          end
        end
      end
      S_CSUM: begin
        load_beat = {csum_q, {KEEP_W{1'b1}}, id_q, pend_last_q};
        if (free) begin
          load    = 1'b1;
          acc_d   = '0;
          state_d = S_DATA;
        end
      end
    endcase
  end

  csum_out_reg #(.W(BEAT_W)) u_out_reg (
    .clock       (clock),
    .reset       (reset),
    .load_i      (load),
    .beat_i      (load_beat),
    .out_ready_i (out_ready),
    .beat_o      (out_beat),
    .valid_o     (out_valid),
    .free_o      (free)
  );

  assign {out, out_keep, out_id, out_last} = out_beat;

endmodule

// File: doc/caesar_csum_inserter.md
Name: caesar_csum_inserter

Overview:
- Transmit-side stage sitting directly upstream of the checksum-stripping stage.
- Takes a 512-bit AXI-Stream-like data stream and inserts one checksum beat after every GROUP data beats, and after the final beat of every packet.
- Each checksum beat carries the byte-masked XOR of the data beats since the previous checksum beat, so the downstream stage can drop it at a fixed cadence.
- Full ready/valid handshake on both sides; one output register stage.

Parameters:
- DATA_W, 512, data width in bits (multiple of 8).
- KEEP_W, DATA_W/8, byte-enable width.
- ID_W, 6, stream id width.
- GROUP, 4, data beats per checksum group (>=2).

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high.
- inp_data  in  DATA_W  input beat data.
- inp_valid  in  1  input beat valid.
- inp_ready  out  1  input beat accepted when inp_valid && inp_ready.
- inp_keep  in  KEEP_W  byte enables.
- inp_id  in  ID_W  stream id.
- inp_last  in  1  last data beat of packet.
- out  out  DATA_W  output beat data.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts when out_valid && out_ready.
- out_keep  out  KEEP_W  output byte enables.
- out_id  out  ID_W  output stream id.
- out_last  out  1  last beat of packet (always a checksum beat).

Behaviour:
- Reset:
  - out_valid=0; out, out_keep, out_id and out_last all 0.
  - Accumulator and counter 0; state DATA.
  - A partial group is discarded.
- Output register:
  - free = !out_valid || out_ready.
  - Registered outputs; a beat moves to the outputs one cycle after it is accepted.
  - When out_valid is held with out_ready=0, all out* remain stable.
- FSM DATA:
  - inp_ready = free.
  - On accept, the output register loads inp_data, inp_keep and inp_id, with out_last forced to 0.
  - masked = inp_data with bytes where inp_keep=0 zeroed.
  - csum_next = acc ^ masked, latched into the csum register.
  - cnt increments, and the id is latched.
  - If cnt==GROUP-1 or inp_last: go to CSUM, latch pend_last=inp_last, reset cnt.
  - Otherwise acc <= csum_next.
- FSM CSUM:
  - inp_ready=0.
  - When free, the output register loads the checksum beat: out=csum, out_keep=all ones, out_id=latched id, out_last=pend_last.
  - acc cleared; go to DATA.
- inp_last on the GROUP-th beat inserts exactly one checksum beat, with out_last=1.
- A single-beat packet produces one data beat followed by one checksum beat.
- Throughput: GROUP data beats per GROUP+1 output beats at full rate.
- No bubble is added beyond the inserted beat when out_ready=1 continuously.
- inp_valid=0 mid-group: state and counter are held; no timeout flush.
- An id change mid-group is not checked; the checksum beat takes the id of the group's last data beat.
- Input signals are ignored while inp_ready=0.
- Reset asserted in any state takes effect on the next edge and overrides all handshakes.

Decomposition:
- Package csum_pkg holds:
  - GROUP_DEFAULT;
  - typedef beat_t as a struct {data, keep, id, last};
  - typedef enum state_t {S_DATA, S_CSUM};
  - function keep_mask(data, keep).
- One natural sub-module: csum_out_reg, the single-entry output register exposing free.

Test Plan:
- 8-beat packet, keep all ones, data 8 beats each 64'h1 replicated, out_ready=1:
  - output 10 beats: D D D D C D D D D C;
  - both C beats all-zero data, out_last=1 only on the 10th;
  - inp_ready low exactly 2 cycles.
- 3-beat packet, data A, B, C, keep all ones -> 4 output beats; 4th = A^B^C with out_last=1 and out_keep all ones.
- 1-beat packet, data 512'hFF.., keep=64'h1 -> data beat with keep=1, then checksum beat = 512'hFF (byte 0 only).
- out_ready held 0 for 5 cycles mid-group -> out* stable, inp_ready=0, no beat lost or duplicated; order intact after release.
- Reset asserted after 2 beats of a group -> out_valid=0 next cycle; the next 4-beat packet's checksum excludes the pre-reset beats.
- Random inp_valid/out_ready at 50% over 1000 packets of 1..20 beats:
  - scoreboard recomputes checksums;
  - checksum beat count = ceil(len/4) per packet.
